cpu_fetch_unit: RTL
===================

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program counter and instruction-memory address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the instruction width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum wait cycles for an instruction-memory acknowledge.
REQ-004 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: SHALL be the asynchronous, active-high reset.
REQ-006 Port loadIR, input, 1: SHALL be the controller strobe requesting an instruction fetch at the current PC.
REQ-007 Port loadPC, input, 1: SHALL be the controller strobe requesting a PC load.
REQ-008 Port incPC, input, 1: SHALL be the controller strobe requesting PC+1.
REQ-009 Port selA, input, 1: SHALL select the jump target (ir[ADDR_W-1:0]) as the PC load source.
REQ-010 Port imem_req, output, 1: SHALL be the instruction-memory request, held until acknowledge or timeout.
REQ-011 Port imem_addr, output, ADDR_W: SHALL be the fetch address, stable while imem_req is high.
REQ-012 Port imem_ack, input, 1: SHALL be the instruction-memory acknowledge, qualifying imem_rdata.
REQ-013 Port imem_rdata, input, DATA_W: SHALL be the instruction word returned by memory.
REQ-014 Port pc, output, ADDR_W: SHALL be the current program counter.
REQ-015 Port ir, output, DATA_W: SHALL be the instruction register.
REQ-016 Port opcode, output, 4: SHALL equal ir[DATA_W-1:DATA_W-4] combinationally.
REQ-017 Port ir_valid, output, 1: SHALL be high when ir holds a word from a completed fetch.
REQ-018 Port busy, output, 1: SHALL be high while a fetch is outstanding.
REQ-019 Port fetch_err, output, 1: SHALL be a sticky flag set on fetch timeout.
REQ-020 Port overrun, output, 1: SHALL be a sticky flag set when loadIR arrives while busy.

Function
REQ-021 The fetch FSM SHALL have states IDLE and WAIT.
REQ-022 IDLE with loadIR at cycle N: imem_addr SHALL be the PC value sampled at N, imem_req and busy SHALL go high at N+1, ir_valid SHALL clear, and the FSM SHALL enter WAIT.
REQ-023 WAIT with imem_ack at cycle M: ir SHALL load imem_rdata, ir_valid SHALL be set, imem_req and busy SHALL go low at M+1, and the FSM SHALL return to IDLE.
REQ-024 imem_ack outside WAIT SHALL be ignored.
REQ-025 A wait counter SHALL clear on WAIT entry and increment each WAIT cycle without ack; after TIMEOUT cycles without ack, imem_req/busy SHALL drop, ir SHALL hold, ir_valid SHALL stay 0, fetch_err SHALL set, and the FSM SHALL return to IDLE.
REQ-026 loadIR in WAIT SHALL be ignored and SHALL set overrun.
REQ-027 PC update priority SHALL be: loadPC&selA -> pc <= ir[ADDR_W-1:0]; else incPC -> pc <= pc+1; else hold.
REQ-028 loadPC without selA SHALL leave pc unchanged.
REQ-029 PC increment SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-030 PC updates SHALL be accepted in both states and SHALL NOT change imem_addr during an outstanding fetch.
REQ-031 loadIR and incPC in the same IDLE cycle SHALL fetch the pre-increment PC.

Reset
REQ-032 On rst: pc=0, ir=0, imem_addr=0, imem_req=0, ir_valid=0, busy=0, fetch_err=0, overrun=0, wait counter=0, FSM=IDLE, all immediately, independent of clk.
REQ-033 rst asserted during WAIT SHALL abandon the fetch; a later ack SHALL be ignored.
REQ-034 fetch_err and overrun SHALL clear only on rst.

Structure
REQ-035 Package cpu_pkg SHALL hold the fetch-FSM state encoding, the opcode width (4), and the default ADDR_W/DATA_W/TIMEOUT values.
REQ-036 The PC register with its load/increment priority SHALL be a sub-module cpu_pc_counter; everything else SHALL stay in cpu_fetch_unit.

Verification
REQ-037 Reset, loadIR pulse, ack 3 cycles later with imem_rdata=16'h4A05 -> imem_addr=8'h00, ir=16'h4A05, opcode=4'h4, ir_valid=1, busy low on the cycle after ack.
REQ-038 pc=8'hFF, incPC pulse -> pc=8'h00.
REQ-039 ir=16'h7023, loadPC+selA+incPC in the same cycle -> pc=8'h23.
REQ-040 loadIR with no ack for 15 cycles -> imem_req drops, fetch_err=1, ir unchanged, ir_valid=0.
REQ-041 Second loadIR during WAIT, then incPC during WAIT -> overrun=1, imem_addr unchanged until ack, pc incremented.
REQ-042 rst mid-WAIT, then ack with 16'hBEEF -> all outputs at reset values, ir stays 16'h0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch path: FSM encoding, opcode width and
// default geometry used by the fetch unit and its PC sub-module.
package cpu_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;
  localparam int OPCODE_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/cpu_pc_counter.sv
// Program counter register: a jump load beats an increment, otherwise it holds.
// The increment wraps silently at the top of the address space.
module cpu_pc_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: issues one memory request per loadIR, captures the
// returned word into IR, and bounds each wait with a timeout.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loadIR,
  input  logic                loadPC,
  input  logic                incPC,
  input  logic                selA,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic                ir_valid,
  output logic                busy,
  output logic                fetch_err,
  output logic                overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  // Jump target comes from the low bits of the instruction currently held.
  cpu_pc_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (loadPC & selA),
    .inc_i     (incPC),
    .load_val_i(ir_q[ADDR_W-1:0]),
    .pc_o      (pc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (loadIR) begin
          addr_d  = pc;
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (loadIR) begin
          ovr_d = 1'b1;
        end
        // An ack on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign imem_req  = (state_q == WAIT);
  assign busy      = (state_q == WAIT);
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[DATA_W-1 -: OPCODE_W];
  assign ir_valid  = vld_q;
  assign fetch_err = err_q;
  assign overrun   = ovr_q;

endmodule
